// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: iterative radix-2 multiply / restoring divide for the M-class ALU ops
module alu_muldiv_unit #(
   parameter int WIDTH = 64
) (
   input  logic             iCLK,
   input  logic             iRST_n,
   input  logic             iSTART,
   input  logic [4:0]       iALUControl,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   output logic             oBUSY,
   output logic             oDONE,
   output logic [WIDTH-1:0] oRESULT
);
   localparam logic [4:0] OP_MUL    = 5'd11;
   localparam logic [4:0] OP_MULH   = 5'd12;
   localparam logic [4:0] OP_MULHSU = 5'd14;
   localparam logic [4:0] OP_DIV    = 5'd15;
   localparam logic [4:0] OP_REM    = 5'd17;
   localparam logic [4:0] OP_REMU   = 5'd18;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;
   localparam int CW = $clog2(WIDTH);

   logic [1:0]         state_q, state_d;
   logic [4:0]         op_q, op_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   m_q, m_d, result_q, result_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               neg_q, neg_d, busy_q, done_q;

   logic               is_m, in_div, in_rem, a_neg, b_neg, dz, ovf, accept;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum, div_hi, div_dif;
   logic               div_ge;
   logic [2*WIDTH-1:0] mul_step, div_step, prod;
   logic [WIDTH-1:0]   rsel, rfix, fix_val;

   assign is_m   = iALUControl >= OP_MUL && iALUControl <= OP_REMU;
   assign in_div = iALUControl >= OP_DIV;
   assign in_rem = iALUControl == OP_REM || iALUControl == OP_REMU;
   assign a_neg  = iA[WIDTH-1] & (iALUControl == OP_MULH || iALUControl == OP_MULHSU ||
                                  iALUControl == OP_DIV || iALUControl == OP_REM);
   assign b_neg  = iB[WIDTH-1] & (iALUControl == OP_MULH || iALUControl == OP_DIV ||
                                  iALUControl == OP_REM);
   assign a_mag  = a_neg ? -iA : iA;
   assign b_mag  = b_neg ? -iB : iB;
   assign dz     = in_div && iB == '0;
   assign ovf    = (iALUControl == OP_DIV || iALUControl == OP_REM) &&
                   iA == {1'b1, {(WIDTH-1){1'b0}}} && iB == '1;
   assign accept = iSTART && is_m && (state_q == IDLE || state_q == DONE);

   // acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
   assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};
   assign div_hi   = acc_q[2*WIDTH-1:WIDTH-1];
   assign div_ge   = div_hi >= {1'b0, m_q};
   assign div_dif  = div_hi - {1'b0, m_q};
   assign div_step = {div_ge ? div_dif[WIDTH-1:0] : div_hi[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
   assign prod     = neg_q ? -acc_q : acc_q;
   assign rsel     = (op_q == OP_REM || op_q == OP_REMU) ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
   assign rfix     = neg_q ? -rsel : rsel;
   assign fix_val  = op_q >= OP_DIV ? rfix : (op_q != OP_MUL ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0]);

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      acc_d    = acc_q;
      m_d      = m_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      result_d = result_q;
      if (accept) begin
         op_d  = iALUControl;
         cnt_d = '0;
         neg_d = in_rem ? a_neg : a_neg ^ b_neg;
         if (dz || ovf) begin
            state_d  = DONE;
            result_d = dz ? (in_rem ? iA : '1) : (in_rem ? '0 : iA);
         end else begin
            state_d = CALC;
            acc_d   = {{WIDTH{1'b0}}, in_div ? a_mag : b_mag};
            m_d     = in_div ? b_mag : a_mag;
         end
      end else if (state_q == CALC) begin
         acc_d   = op_q >= OP_DIV ? div_step : mul_step;
         cnt_d   = cnt_q + 1'b1;
         state_d = cnt_q == CW'(WIDTH - 1) ? FIX : CALC;
      end else if (state_q == FIX) begin
         result_d = fix_val;
         state_d  = DONE;
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_q  <= IDLE;
         op_q     <= '0;
         acc_q    <= '0;
         m_q      <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         m_q      <= m_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         result_q <= result_d;
         busy_q   <= state_d == CALC || state_d == FIX;
         done_q   <= state_d == DONE;
      end
   end

   assign oBUSY   = busy_q;
   assign oDONE   = done_q;
   assign oRESULT = result_q;
endmodule
